// File: rtl/mux4x1_beh.sv
// Behavioural 4:1 single-bit mux; the arbiter's sel output steers it to the
// current grantee's data.
module mux4x1_beh (
  input  logic [3:0] data_in,
  input  logic [1:0] sel,
  output logic       out
);

  always_comb out = data_in[sel];

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter sharing one 4:1 mux between four requesters, with a
// bounded tenure so a busy grantee yields after MAX_HOLD cycles if others wait.
module mux4_rr_arbiter #(
  parameter int MAX_HOLD = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic [3:0] grant,
  output logic [1:0] sel,
  output logic       busy
);

  localparam int CNT_W = $clog2(MAX_HOLD + 1);
  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] HOLD_ONE = CNT_W'(1);

  // Handshake: req[i] is a level held high for the whole tenure; grant[i]
  // is the registered answer. No ready path: a granted requester owns the
  // mux until it drops req or is pre-empted.
  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state, state_n;
  logic [3:0]       grant_n;
  logic [1:0]       sel_n;
  logic [1:0]       ptr, ptr_n;
  logic [CNT_W-1:0] hold_cnt, hold_n;
  logic [1:0]       win, cand;
  logic             win_ok;
  logic             take;

  // Rotating scan starting just after the last-served index. While busy,
  // ptr equals the grantee, so the scan reaches every other requester
  // before wrapping back to the grantee.
  always_comb begin
    win    = ptr;
    win_ok = 1'b0;
    cand   = '0;
    for (int k = 1; k <= 4; k++) begin
      cand = ptr + 2'(k);
      if (!win_ok && req[cand]) begin
        win    = cand;
        win_ok = 1'b1;
      end
    end
  end

  always_comb begin
    state_n = state;
    grant_n = grant;
    sel_n   = sel;
    ptr_n   = ptr;
    hold_n  = hold_cnt;
    take    = 1'b0;
    case (state)
      IDLE: begin
        if (win_ok) take = 1'b1;
      end
      BUSY: begin
        if (!req[sel]) begin
          if (win_ok) begin
            take = 1'b1;
          end else begin
            state_n = IDLE;
            grant_n = '0;
            hold_n  = '0;
          end
        end else if (hold_cnt == HOLD_MAX && (req & ~grant) != 4'b0000) begin
          take = 1'b1;
        end else if (hold_cnt != HOLD_MAX) begin
          hold_n = hold_cnt + HOLD_ONE;
        end
      end
      default: state_n = IDLE;
    endcase
    if (take) begin
      state_n = BUSY;
      grant_n = 4'b0001 << win;
      sel_n   = win;
      ptr_n   = win;
      hold_n  = HOLD_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      grant    <= '0;
      sel      <= '0;
      ptr      <= 2'd3;
      hold_cnt <= '0;
      busy     <= 1'b0;
    end else begin
      state    <= state_n;
      grant    <= grant_n;
      sel      <= sel_n;
      ptr      <= ptr_n;
      hold_cnt <= hold_n;
      busy     <= |grant_n;
    end
  end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Bench for mux4_rr_arbiter: reference model feeds an expected queue,
// directed scenarios plus a random phase, mux sweeps on the select output.
module tb_mux4_rr_arbiter;

  localparam int MAX_HOLD = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = 4'b0000;
  logic [3:0] grant;
  logic [1:0] sel;
  logic       busy;
  logic [3:0] data_in = 4'b0000;
  logic       mux_out;

  int checks = 0;
  int failures = 0;

  logic [6:0] exp_q[$];

  int m_owner = -1;
  int m_ptr   = 3;
  int m_hold  = 0;
  int m_sel   = 0;

  mux4_rr_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .grant (grant),
    .sel   (sel),
    .busy  (busy)
  );

  mux4x1_beh u_mux (
    .data_in (data_in),
    .sel     (sel),
    .out     (mux_out)
  );

  // clock/reset
  always #20 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = 3;
    m_hold  = 0;
    m_sel   = 0;
    exp_q.delete();
  endtask

  task automatic model_step(input logic [3:0] r);
    logic       need;
    logic [3:0] oh;
    int         pick;
    need = 1'b1;
    if (m_owner >= 0) begin
      oh = 4'b0001 << m_owner;
      need = !r[m_owner] || (m_hold >= MAX_HOLD && (r & ~oh) != 4'b0000);
    end
    if (need) begin
      pick = -1;
      for (int k = 1; k <= 4; k++) begin
        int i;
        i = (m_ptr + k) % 4;
        if (pick < 0 && r[i]) pick = i;
      end
      if (pick >= 0) begin
        m_owner = pick;
        m_ptr   = pick;
        m_sel   = pick;
        m_hold  = 1;
      end else begin
        m_owner = -1;
        m_hold  = 0;
      end
    end else if (m_hold < MAX_HOLD) begin
      m_hold++;
    end
  endtask

  function automatic logic [1:0] idx_of(input logic [3:0] g);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 0; i < 4; i++) if (g[i]) r = 2'(i);
    return r;
  endfunction

  task automatic compare_out();
    logic [6:0] e;
    if (exp_q.size() == 0) begin
      check("exp_q_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check("grant", {28'd0, grant}, {28'd0, e[6:3]});
      check("sel", {30'd0, sel}, {30'd0, e[2:1]});
      check("busy", {31'd0, busy}, {31'd0, e[0]});
    end
    check("onehot", ($countones(grant) <= 1) ? 32'd1 : 32'd0, 32'd1);
    check("busy_eq_or", {31'd0, busy}, {31'd0, |grant});
    if (busy) check("sel_idx", {30'd0, sel}, {30'd0, idx_of(grant)});
  endtask

  // driver: apply req after a falling edge, check just after the rising edge
  task automatic step(input logic [3:0] r);
    logic [3:0] eg;
    @(negedge clk);
    req = r;
    model_step(r);
    eg = (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
    exp_q.push_back({eg, 2'(m_sel), |eg});
    @(posedge clk);
    #1;
    compare_out();
  endtask

  task automatic mux_sweep();
    logic [3:0] dv;
    for (int v = 0; v < 16; v++) begin
      dv = 4'(v);
      data_in = dv;
      #1;
      check("mux_out", {31'd0, mux_out}, {31'd0, dv[m_sel]});
    end
  endtask

  initial begin
    // 1: reset held with all requesting
    req = 4'b1111;
    @(posedge clk);
    #1;
    check("rst_grant", {28'd0, grant}, 32'd0);
    check("rst_sel", {30'd0, sel}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    mux_sweep();
    #1;
    rst_n = 1'b1;
    model_reset();
    step(4'b1111);
    check("rst_first_grant", {28'd0, grant}, 32'h1);

    // 2: single requester, then release
    for (int i = 0; i < 10; i++) step(4'b0100);
    check("single_grant", {28'd0, grant}, 32'h4);
    mux_sweep();
    step(4'b0000);
    check("single_release_busy", {31'd0, busy}, 32'd0);
    check("single_release_sel", {30'd0, sel}, 32'd2);
    mux_sweep();

    // 3: full round robin from ptr=3
    step(4'b1000);
    step(4'b0000);
    for (int i = 0; i < 20; i++) begin
      step(4'b1111);
      check("rr_seq", {28'd0, grant}, 32'h1 << ((i / 4) % 4));
      check("rr_sel", {30'd0, sel}, 32'((i / 4) % 4));
    end
    mux_sweep();

    // 4: early release hands over without an idle cycle
    step(4'b0010);
    step(4'b1010);
    check("early_grant1", {28'd0, grant}, 32'h2);
    step(4'b1000);
    check("early_grant3", {28'd0, grant}, 32'h8);
    check("early_busy", {31'd0, busy}, 32'd1);
    mux_sweep();

    // 5: wrap from index 3 back to 0
    step(4'b0000);
    step(4'b1001);
    check("wrap_grant0", {28'd0, grant}, 32'h1);
    step(4'b1000);
    check("wrap_grant3", {28'd0, grant}, 32'h8);
    mux_sweep();

    // 6: asynchronous reset in the middle of a tenure
    step(4'b0100);
    step(4'b0100);
    check("pre_async_grant", {28'd0, grant}, 32'h4);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_grant", {28'd0, grant}, 32'd0);
    check("async_busy", {31'd0, busy}, 32'd0);
    check("async_sel", {30'd0, sel}, 32'd0);
    model_reset();
    #1;
    rst_n = 1'b1;
    step(4'b0100);
    check("async_regrant", {28'd0, grant}, 32'h4);
    mux_sweep();

    // random traffic
    for (int i = 0; i < 200; i++) begin
      step(4'($urandom_range(0, 15)));
      if (i % 25 == 0) mux_sweep();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
